// File: rtl/text_fetch_unit.sv
// Instruction-fetch front end: range/alignment check, fixed-latency text memory pipeline,
// and an in-order response FIFO whose credit limit equals the number of in-flight slots.
module text_fetch_unit #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    MEM_ADDR_WIDTH = 14,
    parameter int                    MEM_LATENCY    = 1,
    parameter logic [ADDR_WIDTH-1:0] TEXT_BEGIN     = 32'h00400000,
    parameter logic [ADDR_WIDTH-1:0] TEXT_END       = 32'h0040FFFC,
    parameter logic [DATA_WIDTH-1:0] FAULT_DATA     = 32'h00000001
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_address,
    output logic                      mem_read_enable,
    output logic [MEM_ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0]     mem_q,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_WIDTH-1:0]     resp_data,
    output logic [ADDR_WIDTH-1:0]     resp_address,
    output logic                      resp_fault,
    output logic                      resp_misaligned
);

    localparam int             DEPTH     = MEM_LATENCY + 1;
    localparam int             PW        = $clog2(DEPTH);
    localparam int             CW        = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]  LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [PW-1:0]  ONE_PTR   = PW'(1);
    localparam logic [CW-1:0]  DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]  ONE_CNT   = CW'(1);

    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic                  w_fault;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [CW-1:0]         w_outstanding;

    logic [MEM_LATENCY-1:0]                 r_vld_pipe;
    logic [MEM_LATENCY-1:0][ADDR_WIDTH-1:0] r_addr_pipe;
    logic [MEM_LATENCY-1:0]                 r_flt_pipe;
    logic [MEM_LATENCY-1:0]                 r_mis_pipe;

    logic [DATA_WIDTH-1:0] r_fifo_data [DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_addr [DEPTH];
    logic                  r_fifo_flt  [DEPTH];
    logic                  r_fifo_mis  [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ONE_PTR;
    endfunction

    // Request-side checks; faulting fetches ride the pipeline but never strobe memory
    assign w_misaligned    = (req_address[1:0] != 2'b00);
    assign w_out_of_range  = (req_address < TEXT_BEGIN) || (req_address > TEXT_END);
    assign w_fault         = w_misaligned || w_out_of_range;

    assign mem_address     = req_address[MEM_ADDR_WIDTH+1:2];
    assign w_accept        = req_valid && req_ready;
    assign mem_read_enable = w_accept && !w_fault;

    // A response leaving this cycle frees its credit, which sustains one fetch per cycle
    always_comb begin
        w_outstanding = r_count;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            w_outstanding = w_outstanding + {{(CW-1){1'b0}}, r_vld_pipe[i]};
        end
        if (w_pop) begin
            w_outstanding = w_outstanding - ONE_CNT;
        end
    end

    assign req_ready = reset_n && !flush && (w_outstanding < DEPTH_CNT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe <= '0;
        end else if (flush) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= w_accept;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        r_addr_pipe[0] <= req_address;
        r_flt_pipe[0]  <= w_fault;
        r_mis_pipe[0]  <= w_misaligned;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            r_addr_pipe[i] <= r_addr_pipe[i-1];
            r_flt_pipe[i]  <= r_flt_pipe[i-1];
            r_mis_pipe[i]  <= r_mis_pipe[i-1];
        end
    end

    // Last pipeline stage lines up with mem_q; the credit limit keeps the FIFO from overflowing
    assign w_push = r_vld_pipe[MEM_LATENCY-1];
    assign w_pop  = resp_valid && resp_ready;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= r_flt_pipe[MEM_LATENCY-1] ? FAULT_DATA : mem_q;
            r_fifo_addr[r_wr_ptr] <= r_addr_pipe[MEM_LATENCY-1];
            r_fifo_flt[r_wr_ptr]  <= r_flt_pipe[MEM_LATENCY-1];
            r_fifo_mis[r_wr_ptr]  <= r_mis_pipe[MEM_LATENCY-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next(r_rd_ptr);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
        end
    end

    // Outputs read as zero whenever the FIFO is empty, including straight out of reset
    assign resp_valid      = (r_count != '0);
    assign resp_data       = resp_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign resp_address    = resp_valid ? r_fifo_addr[r_rd_ptr] : '0;
    assign resp_fault      = resp_valid && r_fifo_flt[r_rd_ptr];
    assign resp_misaligned = resp_valid && r_fifo_mis[r_rd_ptr];

endmodule

// File: tb/tb_text_fetch_unit.sv
// Bench for text_fetch_unit (MEM_LATENCY=3): directed vector table, multi-cycle corner
// sequences, and a randomized run checked every cycle against a queue-based reference model.
module tb_text_fetch_unit;

    localparam int          L     = 3;
    localparam int          DEPTH = L + 1;
    localparam logic [31:0] TBEG  = 32'h00400000;
    localparam logic [31:0] TEND  = 32'h0040FFFC;
    localparam logic [31:0] FDAT  = 32'h00000001;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_address = 32'h0;
    logic        mem_read_enable;
    logic [13:0] mem_address;
    logic [31:0] mem_q;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [31:0] resp_address;
    logic        resp_fault;
    logic        resp_misaligned;

    text_fetch_unit #(.MEM_LATENCY(L)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
        .mem_read_enable(mem_read_enable), .mem_address(mem_address), .mem_q(mem_q),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_address(resp_address), .resp_fault(resp_fault), .resp_misaligned(resp_misaligned)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Text memory contents and a fixed-latency memory macro model
    function automatic logic [31:0] memf(input logic [13:0] w);
        return {10'd0, w, 8'h13};
    endfunction

    logic [L-1:0] mq_vld = '0;
    logic [13:0]  mq_addr [L];
    always @(posedge clock) begin
        mq_vld     <= {mq_vld[L-2:0], mem_read_enable};
        mq_addr[0] <= mem_address;
        for (int i = 1; i < L; i++) mq_addr[i] <= mq_addr[i-1];
    end
    assign mem_q = mq_vld[L-1] ? memf(mq_addr[L-1]) : 32'hDEADBEEF;

    // Reference model: every accepted fetch is a queue entry visible L+1 cycles after acceptance
    typedef struct { logic [31:0] addr; longint tv; } pend_t;
    pend_t  pend[$];
    longint cyc = 0;

    function automatic logic is_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < TBEG) || (a > TEND);
    endfunction
    function automatic logic m_rv();
        return reset_n && (pend.size() > 0) && (pend[0].tv <= cyc);
    endfunction
    function automatic logic m_rdy();
        return reset_n && !flush && ((pend.size() - ((m_rv() && resp_ready) ? 1 : 0)) < DEPTH);
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) pend.delete();
        else if (flush) pend.delete();
        else begin
            if (m_rv() && resp_ready) void'(pend.pop_front());
            if (req_valid && pend.size() < DEPTH) pend.push_back('{req_address, cyc + L + 1});
        end
    end

    always @(negedge clock) begin
        chk("mon_ready", req_ready, m_rdy());
        chk("mon_mem_en", mem_read_enable, m_rdy() && req_valid && !is_fault(req_address));
        chk("mon_mem_addr", mem_address, req_address[15:2]);
        chk("mon_resp_valid", resp_valid, m_rv());
        if (m_rv()) begin
            chk("mon_data", resp_data,
                is_fault(pend[0].addr) ? FDAT : memf(pend[0].addr[15:2]));
            chk("mon_addr", resp_address, pend[0].addr);
            chk("mon_fault", resp_fault, is_fault(pend[0].addr));
            chk("mon_mis", resp_misaligned, pend[0].addr[1:0] != 2'b00);
        end
        if (!reset_n) begin
            chk("mon_rst_data", resp_data, 0);
            chk("mon_rst_addr", resp_address, 0);
            chk("mon_rst_flags", {resp_fault, resp_misaligned}, 0);
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        flt;
        logic        mis;
        logic        en;
    } vec_t;
    vec_t vt [9];

    task automatic check_zero(input string tag);
        chk({tag, ".ready"}, req_ready, 0);
        chk({tag, ".mem_en"}, mem_read_enable, 0);
        chk({tag, ".rvalid"}, resp_valid, 0);
        chk({tag, ".rdata"}, resp_data, 0);
        chk({tag, ".raddr"}, resp_address, 0);
        chk({tag, ".rflags"}, {resp_fault, resp_misaligned}, 0);
    endtask

    // Single fetch from idle: response must appear exactly in cycle L+1
    task automatic do_single(input vec_t v, input string tag);
        @(posedge clock); #1;
        req_valid = 1'b1; req_address = v.addr; resp_ready = 1'b1;
        @(negedge clock);
        chk({tag, ".ready"}, req_ready, 1);
        chk({tag, ".mem_en"}, mem_read_enable, v.en);
        @(posedge clock); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= L; k++) begin
            @(negedge clock);
            chk({tag, ".early"}, resp_valid, 0);
        end
        @(negedge clock);
        chk({tag, ".valid"}, resp_valid, 1);
        chk({tag, ".data"}, resp_data, v.data);
        chk({tag, ".addr"}, resp_address, v.addr);
        chk({tag, ".fault"}, resp_fault, v.flt);
        chk({tag, ".mis"}, resp_misaligned, v.mis);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [13:0] w;
        logic [1:0]  lo;
        w  = 14'($urandom());
        lo = 2'($urandom_range(1, 3));
        case ($urandom_range(0, 7))
            0, 1, 2: return {16'h0040, w, 2'b00};
            3:       return {16'h0040, w, lo};
            4:       return 32'h0040FFFC;
            5:       return 32'h00410000;
            6:       return 32'h003FFFFC;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int got;
        vt[0] = '{32'h00400000, 32'h00000013, 1'b0, 1'b0, 1'b1};
        vt[1] = '{32'h00400002, 32'h00000001, 1'b1, 1'b1, 1'b0};
        vt[2] = '{32'h0040FFFC, 32'h003FFF13, 1'b0, 1'b0, 1'b1};
        vt[3] = '{32'h00410000, 32'h00000001, 1'b1, 1'b0, 1'b0};
        vt[4] = '{32'h003FFFFC, 32'h00000001, 1'b1, 1'b0, 1'b0};
        vt[5] = '{32'h00400104, 32'h00004113, 1'b0, 1'b0, 1'b1};
        vt[6] = '{32'hFFFFFFFC, 32'h00000001, 1'b1, 1'b0, 1'b0};
        vt[7] = '{32'h0040FFFF, 32'h00000001, 1'b1, 1'b1, 1'b0};
        vt[8] = '{32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0};

        #2;
        check_zero("reset");
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 9; i++) do_single(vt[i], $sformatf("vec%0d", i));

        // Eight back-to-back fetches drain one per cycle in order
        for (int c = 0; c < 8 + L + 1; c++) begin
            @(posedge clock); #1;
            req_valid = (c < 8); req_address = TBEG + 32'(c * 16); resp_ready = 1'b1;
            @(negedge clock);
            if (c < 8) chk("b2b.ready", req_ready, 1);
            if (c >= L + 1) begin
                chk("b2b.valid", resp_valid, 1);
                chk("b2b.addr", resp_address, TBEG + 32'((c - L - 1) * 16));
            end
        end

        // Backpressure: credits run out after DEPTH accepts and the head stays put
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
            req_valid = (c < 6); req_address = TBEG + 32'h100 + 32'(c * 4); resp_ready = 1'b0;
            @(negedge clock);
            if (c < 6) chk("bp.ready", req_ready, (c < DEPTH));
            if (c >= L + 1) begin
                chk("bp.valid", resp_valid, 1);
                chk("bp.addr", resp_address, 32'h00400100);
                chk("bp.data", resp_data, 32'h00004013);
            end
        end
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock); #1;
            req_valid = 1'b0; resp_ready = 1'b1;
            @(negedge clock);
            if (resp_valid) got++;
        end
        chk("bp.drain_count", got, DEPTH);

        // Flush with L fetches in flight and one queued response
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
            req_valid = 1'b1; req_address = TBEG + 32'(c * 4); resp_ready = 1'b0;
            @(negedge clock);
            chk("fl.ready", req_ready, 1);
        end
        @(posedge clock); #1;
        flush = 1'b1; req_address = TBEG + 32'h40;
        @(negedge clock);
        chk("fl.ready_in_flush", req_ready, 0);
        chk("fl.mem_en_in_flush", mem_read_enable, 0);
        chk("fl.queued", resp_valid, 1);
        @(posedge clock); #1;
        flush = 1'b0; req_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            chk("fl.no_stale", resp_valid, 0);
        end
        do_single(vt[0], "fl.after");

        // Asynchronous reset in the middle of a stream
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            req_valid = 1'b1; req_address = TBEG + 32'(c * 4); resp_ready = 1'b1;
        end
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1 check_zero("rst_mid");
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1; req_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk("rst_mid.no_resp", resp_valid, 0);
        end

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock); #1;
            req_valid   = ($urandom_range(0, 9) < 7);
            req_address = rand_addr();
            resp_ready  = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 39) == 0);
        end
        @(posedge clock); #1;
        req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1;
        repeat (10) @(posedge clock);
        #1 chk("final.idle", resp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
